// File: rtl/clock_set_pkg.sv
// Shared encodings, BCD digit limits and key auto-repeat timing for the clock setting controller.
package clock_set_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SET_TIME  = 2'd1,
    SET_ALARM = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    HOUR = 2'd0,
    MIN  = 2'd1,
    SEC  = 2'd2
  } field_t;

  localparam logic [3:0] MAX_GE          = 4'd9;
  localparam logic [3:0] MAX_MIN_SHI     = 4'd5;
  localparam logic [3:0] MAX_HOUR_SHI    = 4'd2;
  // Units limit once the tens digit of the hour has reached its maximum (23 wraps).
  localparam logic [3:0] MAX_HOUR_GE_TOP = 4'd3;

  localparam int REPEAT_FIRST_MS = 500;
  localparam int REPEAT_NEXT_MS  = 100;

endpackage

// File: rtl/key_debounce.sv
// One push-button front end: 2-flop synchronizer, stability counter and a one-cycle press strobe.
// The debounced level only changes after DB_CYC consecutive cycles of a differing synchronized level.
module key_debounce #(
  parameter int DB_CYC = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic level,
  output logic press
);

  localparam int CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= 2'b11;
      cnt     <= '0;
      level   <= 1'b1;
      level_d <= 1'b1;
      press   <= 1'b0;
    end else begin
      sync    <= {sync[0], key};
      level_d <= level;
      press   <= level_d & ~level;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYC - 1)) begin
        cnt   <= '0;
        level <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Front-panel setting controller: debounced mode/sel/inc keys drive a mode FSM that edits staged
// time and alarm BCD digits. Define KEY_REPEAT_EN to auto-repeat a held inc key.
module clock_set_ctrl
  import clock_set_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_sel,
  input  logic       key_inc,
  output logic       set_time_finish,
  output logic [3:0] set_sec_ge,
  output logic [3:0] set_sec_shi,
  output logic [3:0] set_min_ge,
  output logic [3:0] set_min_shi,
  output logic [3:0] set_hour_ge,
  output logic [3:0] set_hour_shi,
  output logic       clock_en,
  output logic [3:0] clock_min_ge,
  output logic [3:0] clock_min_shi,
  output logic [3:0] clock_hour_ge,
  output logic [3:0] clock_hour_shi,
  output logic [1:0] edit_state,
  output logic [1:0] edit_field
);

  localparam int DB_CYC = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;

  logic mode_lvl, mode_press, sel_lvl, sel_press, inc_lvl, inc_press;
  logic inc_ev, lvl_unused;

  key_debounce #(.DB_CYC(DB_CYC)) u_mode (.clk(clk), .rst_n(rst_n), .key(key_mode), .level(mode_lvl), .press(mode_press));
  key_debounce #(.DB_CYC(DB_CYC)) u_sel  (.clk(clk), .rst_n(rst_n), .key(key_sel),  .level(sel_lvl),  .press(sel_press));
  key_debounce #(.DB_CYC(DB_CYC)) u_inc  (.clk(clk), .rst_n(rst_n), .key(key_inc),  .level(inc_lvl),  .press(inc_press));

`ifdef KEY_REPEAT_EN
  localparam int RPT_FIRST = CLK_FREQ_HZ / 1000 * REPEAT_FIRST_MS;
  localparam int RPT_NEXT  = CLK_FREQ_HZ / 1000 * REPEAT_NEXT_MS;

  logic [31:0] rpt_cnt;
  logic        rpt_armed;
  logic        rpt_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
      rpt_ev    <= 1'b0;
    end else if (inc_lvl || mode_press || sel_press) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
      rpt_ev    <= 1'b0;
    end else if (rpt_cnt == 32'(rpt_armed ? RPT_NEXT - 1 : RPT_FIRST - 1)) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b1;
      rpt_ev    <= 1'b1;
    end else begin
      rpt_cnt <= rpt_cnt + 32'd1;
      rpt_ev  <= 1'b0;
    end
  end

  assign inc_ev     = inc_press | rpt_ev;
  assign lvl_unused = &{mode_lvl, sel_lvl};
`else
  assign inc_ev     = inc_press;
  assign lvl_unused = &{mode_lvl, sel_lvl, inc_lvl};
`endif

  // mode outranks sel outranks inc; losers in the same cycle are dropped
  logic ev_mode, ev_sel, ev_inc;
  assign ev_mode = mode_press;
  assign ev_sel  = sel_press & ~mode_press;
  assign ev_inc  = inc_ev & ~mode_press & ~sel_press;

  function automatic logic [7:0] inc_sexa(input logic [7:0] v);
    if (v[3:0] != MAX_GE) return {v[7:4], v[3:0] + 4'd1};
    if (v[7:4] == MAX_MIN_SHI) return 8'h00;
    return {v[7:4] + 4'd1, 4'd0};
  endfunction

  function automatic logic [7:0] inc_hour(input logic [7:0] v);
    if (v == {MAX_HOUR_SHI, MAX_HOUR_GE_TOP}) return 8'h00;
    if (v[3:0] == MAX_GE) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  state_t     state;
  field_t     field;
  logic [7:0] t_hour, t_min, t_sec, a_hour, a_min;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      field           <= HOUR;
      set_time_finish <= 1'b0;
      clock_en        <= 1'b0;
      t_hour          <= '0;
      t_min           <= '0;
      t_sec           <= '0;
      a_hour          <= '0;
      a_min           <= '0;
    end else begin
      set_time_finish <= 1'b0;
      case (state)
        IDLE: begin
          if (ev_mode) begin
            state <= SET_TIME;
            field <= HOUR;
          end else if (ev_sel) begin
            clock_en <= ~clock_en;
          end
        end
        SET_TIME: begin
          if (ev_mode) begin
            state           <= SET_ALARM;
            field           <= HOUR;
            set_time_finish <= 1'b1;
          end else if (ev_sel) begin
            field <= (field == HOUR) ? MIN : ((field == MIN) ? SEC : HOUR);
          end else if (ev_inc) begin
            case (field)
              HOUR:    t_hour <= inc_hour(t_hour);
              MIN:     t_min  <= inc_sexa(t_min);
              default: t_sec  <= inc_sexa(t_sec);
            endcase
          end
        end
        SET_ALARM: begin
          if (ev_mode) begin
            state <= IDLE;
            field <= HOUR;
          end else if (ev_sel) begin
            field <= (field == HOUR) ? MIN : HOUR;
          end else if (ev_inc) begin
            if (field == HOUR) a_hour <= inc_hour(a_hour);
            else               a_min  <= inc_sexa(a_min);
          end
        end
        default: begin
          state <= IDLE;
          field <= HOUR;
        end
      endcase
    end
  end

  assign {set_hour_shi, set_hour_ge}     = t_hour;
  assign {set_min_shi, set_min_ge}       = t_min;
  assign {set_sec_shi, set_sec_ge}       = t_sec;
  assign {clock_hour_shi, clock_hour_ge} = a_hour;
  assign {clock_min_shi, clock_min_ge}   = a_min;
  assign edit_state = state;
  assign edit_field = field;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed key sequences plus random key combinations, checked against
// an integer-valued model of the time/alarm/mode rules.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_mode = 1'b1, key_sel = 1'b1, key_inc = 1'b1;
  logic       set_time_finish, clock_en;
  logic [3:0] set_sec_ge, set_sec_shi, set_min_ge, set_min_shi, set_hour_ge, set_hour_shi;
  logic [3:0] clock_min_ge, clock_min_shi, clock_hour_ge, clock_hour_shi;
  logic [1:0] edit_state, edit_field;

  clock_set_ctrl #(.CLK_FREQ_HZ(1000), .DEBOUNCE_MS(3)) dut (
    .clk(clk), .rst_n(rst_n), .key_mode(key_mode), .key_sel(key_sel), .key_inc(key_inc),
    .set_time_finish(set_time_finish),
    .set_sec_ge(set_sec_ge), .set_sec_shi(set_sec_shi),
    .set_min_ge(set_min_ge), .set_min_shi(set_min_shi),
    .set_hour_ge(set_hour_ge), .set_hour_shi(set_hour_shi),
    .clock_en(clock_en),
    .clock_min_ge(clock_min_ge), .clock_min_shi(clock_min_shi),
    .clock_hour_ge(clock_hour_ge), .clock_hour_shi(clock_hour_shi),
    .edit_state(edit_state), .edit_field(edit_field)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_miss = 0, fin_seen = 0;
  int m_state, m_field, m_hr, m_mn, m_sc, m_ahr, m_amn, m_en, m_fin = 0;

  // every high cycle of the strobe is counted, so a stretched pulse shows up as an extra count
  always @(negedge clk) if (set_time_finish) fin_seen++;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int bcd(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  function automatic void model_reset();
    m_state = 0; m_field = 0; m_en = 0;
    m_hr = 0; m_mn = 0; m_sc = 0; m_ahr = 0; m_amn = 0;
  endfunction

  function automatic void model_event(input bit m, input bit s, input bit i);
    if (m) begin
      if (m_state == 1) m_fin++;
      m_state = (m_state + 1) % 3;
      m_field = 0;
    end else if (s) begin
      if (m_state == 0)      m_en = 1 - m_en;
      else if (m_state == 1) m_field = (m_field + 1) % 3;
      else                   m_field = 1 - m_field;
    end else if (i) begin
      if (m_state == 1) begin
        if (m_field == 0)      m_hr = (m_hr + 1) % 24;
        else if (m_field == 1) m_mn = (m_mn + 1) % 60;
        else                   m_sc = (m_sc + 1) % 60;
      end else if (m_state == 2) begin
        if (m_field == 0) m_ahr = (m_ahr + 1) % 24;
        else              m_amn = (m_amn + 1) % 60;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ":state"}, int'(edit_state), m_state);
    if (m_state != 0) chk({tag, ":field"}, int'(edit_field), m_field);
    chk({tag, ":en"},    int'(clock_en), m_en);
    chk({tag, ":hour"},  int'({set_hour_shi, set_hour_ge}), bcd(m_hr));
    chk({tag, ":min"},   int'({set_min_shi, set_min_ge}), bcd(m_mn));
    chk({tag, ":sec"},   int'({set_sec_shi, set_sec_ge}), bcd(m_sc));
    chk({tag, ":ahour"}, int'({clock_hour_shi, clock_hour_ge}), bcd(m_ahr));
    chk({tag, ":amin"},  int'({clock_min_shi, clock_min_ge}), bcd(m_amn));
    chk({tag, ":fin"},   fin_seen, m_fin);
  endtask

  task automatic press(input bit m, input bit s, input bit i);
    @(posedge clk); #1;
    key_mode = ~m; key_sel = ~s; key_inc = ~i;
    repeat (5) @(posedge clk);
    #1;
    key_mode = 1'b1; key_sel = 1'b1; key_inc = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    model_event(m, s, i);
    check_all("press");
  endtask

  initial begin
    model_reset();
    #1;
    check_all("reset");
    chk("reset_field", int'(edit_field), 0);
    chk("reset_finish", int'(set_time_finish), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    press(1, 0, 0);
    repeat (23) press(0, 0, 1);
    chk("hour_23", int'({set_hour_shi, set_hour_ge}), 'h23);
    press(0, 0, 1);
    chk("hour_wrap", int'({set_hour_shi, set_hour_ge}), 'h00);
    repeat (7) press(0, 0, 1);
    press(0, 1, 0);
    repeat (60) press(0, 0, 1);
    chk("min_wrap", int'({set_min_shi, set_min_ge}), 'h00);
    chk("hour_kept", int'({set_hour_shi, set_hour_ge}), 'h07);

    // 3-cycle press on inc: output moves exactly DB_CYC+4 = 7 cycles after the raw edge
    @(posedge clk); #1;
    key_inc = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      if (k == 6) chk("latency_before", int'(set_min_ge), m_mn % 10);
      if (k == 7) chk("latency_after", int'(set_min_ge), (m_mn + 1) % 10);
      if (k == 3) key_inc = 1'b1;
    end
    repeat (10) @(posedge clk);
    #1;
    model_event(0, 0, 1);
    check_all("single_event");

    // 2-cycle glitch must be filtered out
    @(posedge clk); #1;
    key_inc = 1'b0;
    repeat (2) @(posedge clk);
    #1 key_inc = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_all("glitch");

    press(1, 0, 0);
    chk("to_alarm", int'(edit_state), 2);
    press(1, 0, 0);
    press(0, 1, 0);
    chk("en_on", int'(clock_en), 1);
    press(0, 1, 0);
    chk("en_off", int'(clock_en), 0);
    press(1, 0, 1);
    chk("mode_beats_inc", int'(edit_state), 1);
    chk("mode_beats_inc_hour", int'({set_hour_shi, set_hour_ge}), 'h07);

    for (int n = 0; n < 150; n++) begin
      int unsigned r;
      r = $urandom_range(1, 7);
      press(r[0], r[1], r[2]);
    end

    for (int k = 0; k < 3 && m_state != 2; k++) press(1, 0, 0);
    for (int k = 0; k < 24 && m_ahr != 12; k++) press(0, 0, 1);
    chk("alarm_12", int'({clock_hour_shi, clock_hour_ge}), 'h12);

    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_field", int'(edit_field), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_finish", fin_seen, m_fin);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Front-panel setting controller for the digital clock. It debounces three raw push-buttons and runs a mode state machine in which the user edits the time and alarm digits. It drives the BCD setting inputs of the time-keeping stage: the `set_*` time digits, the `set_time_finish` strobe, `clock_en` and the `clock_*` alarm digits. It sits directly upstream of the time-keeping stage.

## Interface
- CLK_FREQ_HZ, 50_000_000, system clock frequency.
- DEBOUNCE_MS, 20, required stable time of a key level; DB_CYC = CLK_FREQ_HZ/1000*DEBOUNCE_MS.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- key_mode, key_sel, key_inc  in  1 each  raw buttons, active-low, asynchronous to clk.
- set_time_finish  out  1  one-cycle commit strobe for the time digits.
- set_sec_ge, set_sec_shi, set_min_ge, set_min_shi, set_hour_ge, set_hour_shi  out  4 each  staged time, BCD.
- clock_en  out  1  alarm enable.
- clock_min_ge, clock_min_shi, clock_hour_ge, clock_hour_shi  out  4 each  alarm time, BCD.
- edit_state  out  2  current mode: 0 IDLE, 1 SET_TIME, 2 SET_ALARM.
- edit_field  out  2  field being edited: 0 hour, 1 min, 2 sec.

## Operation
- Each key passes through a 2-flop synchronizer and then a debouncer.
  - The debounced level follows the synchronized level only after it has held stable for DB_CYC consecutive cycles.
  - A press event is a one-cycle strobe on the debounced 1→0 transition. Releases generate no event.
- Event priority in the same cycle: mode > sel > inc. Lower-priority events in that cycle are discarded.
- IDLE:
  - mode → SET_TIME, edit_field=hour.
  - sel toggles clock_en.
  - inc is ignored.
- SET_TIME:
  - sel advances edit_field hour→min→sec→hour.
  - inc increments the selected field.
  - mode → SET_ALARM, edit_field=hour, and set_time_finish pulses in that same transition cycle.
- SET_ALARM:
  - sel toggles edit_field hour↔min.
  - inc increments the selected alarm field.
  - mode → IDLE.
- BCD increment rules:
  - min/sec: ge 9→0 with shi+1; 59→00.
  - hour: 23→00; 09→10; 19→20.
  - Seconds are not edited in SET_ALARM.
- Digits never hold non-BCD values. The shi digits are bounded 0–5 (min/sec) and 0–2 (hour).
- All digit outputs are registered and held stable between edits. The downstream stage samples them on set_time_finish.

## Timing
- Reset values:
  - all digit outputs 0.
  - set_time_finish 0, clock_en 0.
  - edit_state IDLE, edit_field 0.
  - debounced levels 1 (released), all counters 0.
- Latency from raw key edge (held stable) to output change: 2 sync + DB_CYC + 1 event + 1 update, i.e. DB_CYC+4 cycles.
- Bounce shorter than DB_CYC restarts the counter and produces no event.
- set_time_finish is high for exactly 1 cycle per SET_TIME exit and never in any other state.
- Reset asserted mid-edit aborts the edit. All outputs return to reset values immediately (asynchronously), with no set_time_finish pulse.
- A held key produces one event only, unless KEY_REPEAT_EN is defined.

## Configuration
- Macro KEY_REPEAT_EN.
- Defined: key_inc held pressed for 500 ms generates an extra inc event, then one every 100 ms while still held. Periods are derived from CLK_FREQ_HZ. The repeat timer resets on release or on any mode/sel event.
- Undefined: no repeat logic is present; one event per press.

## Structure
- Shared package/header clock_set_pkg holds:
  - state encodings IDLE/SET_TIME/SET_ALARM.
  - field codes HOUR/MIN/SEC.
  - BCD limits (MAX_HOUR_SHI=2, MAX_MIN_SHI=5, etc.).
  - repeat timing constants.
- Sub-module key_debounce (synchronizer + counter + press strobe), instantiated three times.
- BCD increment logic stays in clock_set_ctrl.

## Test plan
Bench overrides CLK_FREQ_HZ=1000, DEBOUNCE_MS=3, giving DB_CYC=3.
- Reset → all digits 0, edit_state 0, clock_en 0, set_time_finish 0.
- Press mode, then inc ×23 → set_hour = 2,3. One more inc → 0,0. Press mode → set_time_finish high for 1 cycle, edit_state=2.
- In SET_TIME: sel, then inc ×60 → min wraps 59→00. Hour digits are unchanged.
- Key glitch low for 2 cycles → no event. Key held low 3 cycles → exactly one event, appearing on outputs at cycle 7 after the raw edge.
- In IDLE: press sel twice → clock_en goes 1, then 0. mode and inc pressed in the same cycle → only the mode transition occurs.
- Reset asserted in SET_ALARM with clock_hour=1,2 → outputs cleared asynchronously and edit_state=0, with no set_time_finish pulse.
